// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store stage: funct3 codes, FSM state codes and
// byte-enable patterns.
package riscv_pkg;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;
   localparam logic [2:0] F3Sb  = 3'b000;
   localparam logic [2:0] F3Sh  = 3'b001;
   localparam logic [2:0] F3Sw  = 3'b010;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StWait = 2'd2;
   localparam logic [1:0] StResp = 2'd3;

   localparam logic [3:0] BeByte = 4'b0001;
   localparam logic [3:0] BeHalf = 4'b0011;
   localparam logic [3:0] BeWord = 4'b1111;

endpackage

// File: rtl/lsu_stage_if.sv
// Execute-side handshake, writeback bundle and data-bus signals of the LSU stage.
interface lsu_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        out_valid;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic        out_we;
   logic        fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport slave (
      input  in_valid, alu_result, store_data, is_load, is_store, funct3, rd,
             mem_gnt, mem_rvalid, mem_rdata,
      output in_ready, out_valid, out_rd, out_data, out_we, fault,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output in_valid, alu_result, store_data, is_load, is_store, funct3, rd,
             mem_gnt, mem_rvalid, mem_rdata,
      input  in_ready, out_valid, out_rd, out_data, out_we, fault,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[{addr, 3'b000} +: 8];
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3Lb:    data = {{24{byte_lane[7]}}, byte_lane};
         F3Lh:    data = {{16{half_lane[15]}}, half_lane};
         F3Lbu:   data = {24'd0, byte_lane};
         F3Lhu:   data = {16'd0, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// Single-outstanding load/store stage: registers one op, runs the data-bus
// handshake and emits a one-cycle writeback pulse.
module lsu_stage
   import riscv_pkg::*;
(
   input logic        clk,
   input logic        rst,
   lsu_stage_if.slave bus
);

   logic [1:0]  state_q, state_d;
   logic [4:0]  rd_q, rd_d;
   logic        we_q, we_d;
   logic        fault_q, fault_d;
   logic [31:0] data_q, data_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;

   logic        mem_op, f3_ok, misal, bad;
   logic [3:0]  be_sel;
   logic [31:0] wdata_sel;
   logic [31:0] ext_data;

   load_extend u_load_extend (
      .rdata  (bus.mem_rdata),
      .addr   (off_q),
      .funct3 (funct3_q),
      .data   (ext_data)
   );

   always_comb begin
      mem_op = bus.is_load | bus.is_store;
      f3_ok  = bus.is_load ? (bus.funct3 inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu})
                           : (bus.funct3 inside {F3Sb, F3Sh, F3Sw});
      misal  = ((bus.funct3[1:0] == 2'b01) && bus.alu_result[0]) ||
               ((bus.funct3[1:0] == 2'b10) && (bus.alu_result[1:0] != 2'b00));
      bad    = (bus.is_load && bus.is_store) || !f3_ok || misal;
      case (bus.funct3[1:0])
         2'b00: begin
            be_sel    = BeByte << bus.alu_result[1:0];
            wdata_sel = {4{bus.store_data[7:0]}};
         end
         2'b01: begin
            be_sel    = BeHalf << {bus.alu_result[1], 1'b0};
            wdata_sel = {2{bus.store_data[15:0]}};
         end
         default: begin
            be_sel    = BeWord;
            wdata_sel = bus.store_data;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      we_d     = we_q;
      fault_d  = fault_q;
      data_d   = data_q;
      addr_d   = addr_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               rd_d    = bus.rd;
               fault_d = 1'b0;
               store_d = 1'b0;
               data_d  = bus.alu_result;
               if (!mem_op) begin
                  we_d    = (bus.rd != 5'd0);
                  state_d = StResp;
               end else if (bad) begin
                  // Faulting accesses never touch the bus.
                  we_d    = 1'b0;
                  fault_d = 1'b1;
                  data_d  = 32'd0;
                  state_d = StResp;
               end else begin
                  we_d     = bus.is_load && (bus.rd != 5'd0);
                  addr_d   = {bus.alu_result[31:2], 2'b00};
                  off_d    = bus.alu_result[1:0];
                  be_d     = be_sel;
                  wdata_d  = wdata_sel;
                  store_d  = bus.is_store;
                  funct3_d = bus.funct3;
                  state_d  = StReq;
               end
            end
         end
         StReq: begin
            if (bus.mem_gnt) state_d = store_q ? StResp : StWait;
         end
         StWait: begin
            if (bus.mem_rvalid) begin
               data_d  = ext_data;
               state_d = StResp;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         rd_q     <= '0;
         we_q     <= 1'b0;
         fault_q  <= 1'b0;
         data_q   <= '0;
         addr_q   <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         store_q  <= 1'b0;
         funct3_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         we_q     <= we_d;
         fault_q  <= fault_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
      end
   end

   // mem_req decodes straight from state so an async reset drops it at once.
   assign bus.in_ready  = (state_q == StIdle);
   assign bus.mem_req   = (state_q == StReq);
   assign bus.out_valid = (state_q == StResp);
   assign bus.out_we    = (state_q == StResp) && we_q;
   assign bus.fault     = (state_q == StResp) && fault_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_data  = data_q;
   assign bus.mem_we    = store_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: ALU ops, loads/stores, faults, reset abort and
// back-to-back issue.
module tb_lsu_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_stage_if bus ();

   lsu_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulse = 0;

   always @(posedge clk) if (bus.out_valid) n_pulse <= n_pulse + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
      bus.is_load    = ld;
      bus.is_store   = st;
      bus.funct3     = f3;
      bus.alu_result = a;
      bus.store_data = sd;
      bus.rd         = r;
      bus.in_valid   = 1'b1;
      step();
      bus.in_valid   = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [4:0] r,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
      issue(1'b1, 1'b0, f3, a, 32'h0, r);
      chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
      chk({tag, "_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
      chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
      chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      chk({tag, "_wait_noreq"}, {31'd0, bus.mem_req}, 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      step();
      bus.mem_rvalid = 1'b0;
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_data"}, bus.out_data, exp_data);
      chk({tag, "_owe"}, {31'd0, bus.out_we}, {31'd0, (r != 5'd0)});
      chk({tag, "_rd"}, {27'd0, bus.out_rd}, {27'd0, r});
      step();
      chk({tag, "_done"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      issue(1'b0, 1'b1, f3, a, sd, 5'd9);
      for (int i = 0; i < delay; i++) begin
         chk({tag, "_req_hold"}, {31'd0, bus.mem_req}, 32'd1);
         chk({tag, "_be_hold"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
         step();
      end
      chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
      chk({tag, "_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
      chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
      chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
      chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd1);
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_owe"}, {31'd0, bus.out_we}, 32'd0);
      chk({tag, "_noreq"}, {31'd0, bus.mem_req}, 32'd0);
      chk({tag, "_rd"}, {27'd0, bus.out_rd}, 32'd9);
      step();
   endtask

   task automatic do_fault(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] a);
      issue(ld, st, f3, a, 32'h1111_2222, 5'd3);
      chk({tag, "_noreq"}, {31'd0, bus.mem_req}, 32'd0);
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_fault"}, {31'd0, bus.fault}, 32'd1);
      chk({tag, "_owe"}, {31'd0, bus.out_we}, 32'd0);
      step();
      chk({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      int base;
      bus.in_valid   = 1'b0;
      bus.alu_result = '0;
      bus.store_data = '0;
      bus.is_load    = 1'b0;
      bus.is_store   = 1'b0;
      bus.funct3     = '0;
      bus.rd         = '0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      step();
      step();
      chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_memwe", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_data", bus.out_data, 32'd0);
      rst = 1'b0;
      step();

      // ALU op
      issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
      chk("alu_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("alu_data", bus.out_data, 32'h0000_1234);
      chk("alu_we", {31'd0, bus.out_we}, 32'd1);
      chk("alu_rd", {27'd0, bus.out_rd}, 32'd5);
      chk("alu_noreq", {31'd0, bus.mem_req}, 32'd0);
      chk("alu_fault", {31'd0, bus.fault}, 32'd0);
      step();
      chk("alu_pulse", {31'd0, bus.out_valid}, 32'd0);
      issue(1'b0, 1'b0, 3'b000, 32'hCAFE_0000, 32'h0, 5'd0);
      chk("alu_x0_we", {31'd0, bus.out_we}, 32'd0);
      step();

      // Stores
      do_store("sw", F3Sw, 32'h0000_0100, 32'hDEAD_BEEF, 3, 4'hF, 32'hDEAD_BEEF);
      do_store("sb", F3Sb, 32'h0000_0101, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5);
      do_store("sh", F3Sh, 32'h0000_0102, 32'h1234_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);

      // Loads
      do_load("lb", F3Lb, 32'h0000_0203, 32'h8012_3456, 5'd4, 4'b1000, 32'hFFFF_FF80);
      do_load("lbu", F3Lbu, 32'h0000_0203, 32'h8012_3456, 5'd4, 4'b1000, 32'h0000_0080);
      do_load("lhu", F3Lhu, 32'h0000_0202, 32'hABCD_1234, 5'd6, 4'b1100, 32'h0000_ABCD);
      do_load("lh", F3Lh, 32'h0000_0200, 32'h0000_8001, 5'd7, 4'b0011, 32'hFFFF_8001);
      do_load("lw_x0", F3Lw, 32'h0000_0104, 32'h1357_9BDF, 5'd0, 4'hF, 32'h1357_9BDF);

      // Faults
      do_fault("lw_mis", 1'b1, 1'b0, F3Lw, 32'h0000_0102);
      do_fault("lh_mis", 1'b1, 1'b0, F3Lh, 32'h0000_0201);
      do_fault("ld_f3", 1'b1, 1'b0, 3'b011, 32'h0000_0200);
      do_fault("st_f3", 1'b0, 1'b1, F3Lbu, 32'h0000_0200);
      do_fault("ldst", 1'b1, 1'b1, F3Lw, 32'h0000_0200);

      // Stray rvalid while idle
      bus.mem_rvalid = 1'b1;
      step();
      bus.mem_rvalid = 1'b0;
      chk("stray_rvalid", {31'd0, bus.out_valid}, 32'd0);

      // Reset while requesting drops mem_req without a clock edge
      issue(1'b1, 1'b0, F3Lw, 32'h0000_0300, 32'h0, 5'd7);
      chk("rreq_req", {31'd0, bus.mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rreq_drop", {31'd0, bus.mem_req}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // Reset during WAIT, then a late rvalid
      issue(1'b1, 1'b0, F3Lw, 32'h0000_0300, 32'h0, 5'd7);
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      chk("rwait_req", {31'd0, bus.mem_req}, 32'd0);
      step();
      rst = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5555_AAAA;
      step();
      bus.mem_rvalid = 1'b0;
      chk("rwait_novalid", {31'd0, bus.out_valid}, 32'd0);
      chk("rwait_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      chk("rwait_novalid2", {31'd0, bus.out_valid}, 32'd0);

      // Back-to-back ALU ops with in_valid held high
      base = n_pulse;
      bus.is_load  = 1'b0;
      bus.is_store = 1'b0;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.alu_result = 32'h10 + k;
         bus.rd         = 5'(k + 1);
         chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
         step();
         chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("b2b_data", bus.out_data, 32'h10 + k);
         chk("b2b_busy", {31'd0, bus.in_ready}, 32'd0);
         bus.alu_result = 32'hBAD0_0000 + k;
         step();
      end
      bus.in_valid = 1'b0;
      chk("b2b_count", n_pulse - base, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
